// File: rtl/l2_lookup_sched_if.sv
// Handshake and lookup-side signal bundle for the L2 lookup sequencer.
// The sequencer connects through the slave modport; the environment
// (core request source, forward source, main L2 FSM) uses master.
interface l2_lookup_sched_if #(
    parameter int ADDR_BITS = 32,
    parameter int SET_BITS  = 9,
    parameter int WAY_BITS  = 3
) ();
    logic                 hold;
    logic                 req_valid;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 req_ready;
    logic                 fwd_valid;
    logic [ADDR_BITS-1:0] fwd_addr;
    logic                 fwd_ready;
    logic                 rd_en;
    logic [SET_BITS-1:0]  rd_set;
    logic                 lookup_en;
    logic                 lookup_mode;
    logic [ADDR_BITS-1:0] cur_addr;
    logic                 busy;
    logic                 op_done;
    logic                 evict_adv;
    logic [WAY_BITS-1:0]  evict_way;

    modport slave (
        input  hold, req_valid, req_addr, fwd_valid, fwd_addr, op_done, evict_adv,
        output req_ready, fwd_ready, rd_en, rd_set, lookup_en, lookup_mode,
               cur_addr, busy, evict_way
    );

    modport master (
        output hold, req_valid, req_addr, fwd_valid, fwd_addr, op_done, evict_adv,
        input  req_ready, fwd_ready, rd_en, rd_set, lookup_en, lookup_mode,
               cur_addr, busy, evict_way
    );
endinterface

// File: rtl/l2_lookup_sched.sv
// Front-end sequencer for the L2 tag/state lookup path.
// Arbitrates core requests against forwards (forwards preferred, with a
// bounded streak so a waiting request cannot starve), issues the tag/state
// read, fires the lookup trigger and then waits for the main FSM to finish.
// Also owns the round-robin eviction-way pointer.
module l2_lookup_sched #(
    parameter int ADDR_BITS      = 32,
    parameter int OFFSET_BITS    = 6,
    parameter int SET_BITS       = 9,
    parameter int WAY_BITS       = 3,
    parameter int RD_LAT         = 1,
    parameter int MAX_FWD_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    l2_lookup_sched_if.slave  bus
);

    localparam int STREAK_W = $clog2(MAX_FWD_STREAK + 1);
    localparam int CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WAIT   = 3'd2,
        S_LOOKUP = 3'd3,
        S_BUSY   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 grant_req_s;
    logic                 grant_fwd_s;
    logic [ADDR_BITS-1:0] grant_addr_s;
    logic [STREAK_W-1:0]  streak_r;
    logic [STREAK_W-1:0]  streak_s;
    logic [CNT_W-1:0]     lat_cnt_r;
    logic [CNT_W-1:0]     lat_cnt_s;
    logic [ADDR_BITS-1:0] cur_addr_r;
    logic                 mode_r;
    logic [SET_BITS-1:0]  rd_set_r;
    logic                 rd_en_r;
    logic                 lookup_en_r;
    logic                 busy_r;
    logic [WAY_BITS-1:0]  evict_way_r;

    // Arbitration, streak bookkeeping, read-latency counting and next state.
    always_comb begin
        state_s      = state_r;
        grant_req_s  = 1'b0;
        grant_fwd_s  = 1'b0;
        streak_s     = streak_r;
        lat_cnt_s    = lat_cnt_r;
        grant_addr_s = bus.req_addr;
        case (state_r)
            S_IDLE: begin
                // Grants are gated by rst so ready never shows while in reset.
                if (rst && !bus.hold) begin
                    if (bus.fwd_valid &&
                        !(bus.req_valid && (streak_r == STREAK_W'(MAX_FWD_STREAK)))) begin
                        grant_fwd_s = 1'b1;
                    end else if (bus.req_valid) begin
                        grant_req_s = 1'b1;
                    end else begin
                        grant_req_s = 1'b0;
                    end
                end else begin
                    grant_req_s = 1'b0;
                end
                if (grant_fwd_s) begin
                    grant_addr_s = bus.fwd_addr;
                end else begin
                    grant_addr_s = bus.req_addr;
                end
                if (grant_fwd_s || grant_req_s) begin
                    state_s = S_RD;
                end else begin
                    state_s = S_IDLE;
                end
                // Streak only counts forwards that overtook a waiting request.
                if (!bus.req_valid || grant_req_s) begin
                    streak_s = '0;
                end else if (grant_fwd_s && (streak_r != STREAK_W'(MAX_FWD_STREAK))) begin
                    streak_s = streak_r + STREAK_W'(1);
                end else begin
                    streak_s = streak_r;
                end
            end
            S_RD: begin
                if (RD_LAT == 1) begin
                    state_s = S_LOOKUP;
                end else begin
                    state_s   = S_WAIT;
                    lat_cnt_s = CNT_W'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                lat_cnt_s = lat_cnt_r - CNT_W'(1);
                if (lat_cnt_r <= CNT_W'(1)) begin
                    state_s = S_LOOKUP;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_LOOKUP: begin
                state_s = S_BUSY;
            end
            S_BUSY: begin
                if (bus.op_done) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_BUSY;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered strobes; strobes follow the next state
    // so they are aligned with the cycle the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            streak_r    <= '0;
            lat_cnt_r   <= '0;
            cur_addr_r  <= '0;
            mode_r      <= 1'b0;
            rd_set_r    <= '0;
            rd_en_r     <= 1'b0;
            lookup_en_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            streak_r  <= streak_s;
            lat_cnt_r <= lat_cnt_s;
            if (grant_fwd_s || grant_req_s) begin
                cur_addr_r <= grant_addr_s;
                mode_r     <= grant_fwd_s;
                rd_set_r   <= grant_addr_s[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
            end else begin
                cur_addr_r <= cur_addr_r;
                mode_r     <= mode_r;
                rd_set_r   <= rd_set_r;
            end
            rd_en_r     <= (state_s == S_RD);
            lookup_en_r <= (state_s == S_LOOKUP);
            busy_r      <= (state_s != S_IDLE);
        end
    end

    // Round-robin eviction pointer, free-running and independent of the FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            evict_way_r <= '0;
        end else if (bus.evict_adv) begin
            evict_way_r <= evict_way_r + WAY_BITS'(1);
        end else begin
            evict_way_r <= evict_way_r;
        end
    end

    assign bus.req_ready   = grant_req_s;
    assign bus.fwd_ready   = grant_fwd_s;
    assign bus.rd_en       = rd_en_r;
    assign bus.rd_set      = rd_set_r;
    assign bus.lookup_en   = lookup_en_r;
    assign bus.lookup_mode = mode_r;
    assign bus.cur_addr    = cur_addr_r;
    assign bus.busy        = busy_r;
    assign bus.evict_way   = evict_way_r;

endmodule
